alu_multicycle: RTL

//  Parametrised EX-stage ALU: single-cycle logic/arith ops plus iterative multiply/divide writing HI/LO.

---
 rtl/alu_multicycle.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// EX-stage ALU: single-cycle logic/arithmetic plus iterative shift-add multiply and
// restoring divide into HI/LO, with a start/busy/done handshake and registered outputs.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;      // product high half / partial remainder
    logic [WIDTH-1:0] work_q, work_d;    // multiplier -> product low half / dividend -> quotient
    logic [WIDTH-1:0] opnd_q, opnd_d;    // |multiplicand| or |divisor|
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] alu_result_q, alu_result_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;

    logic             signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs, simple_res;
    logic [WIDTH-1:0] mul_addend, mul_acc_n, mul_work_n;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_acc_n, div_work_n, acc_n, work_n;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix, fix_hi, fix_lo;

    assign signed_op = (operation == OP_MULT) || (operation == OP_DIV);
    assign a_neg     = signed_op && data1[WIDTH-1];
    assign b_neg     = signed_op && data2[WIDTH-1];
    assign a_abs     = a_neg ? (~data1 + 1'b1) : data1;
    assign b_abs     = b_neg ? (~data2 + 1'b1) : data2;

    // One multiply step: conditional add, then shift {carry, acc, work} right by one.
    assign mul_addend = work_q[0] ? opnd_q : {WIDTH{1'b0}};
    assign mul_sum    = {1'b0, acc_q} + {1'b0, mul_addend};
    assign mul_acc_n  = mul_sum[WIDTH:1];
    assign mul_work_n = {mul_sum[0], work_q[WIDTH-1:1]};

    // One restoring-divide step: shift the next dividend bit into the remainder.
    assign div_shift  = {acc_q, work_q[WIDTH-1]};
    assign div_diff   = div_shift - {1'b0, opnd_q};
    assign div_ge     = div_shift >= {1'b0, opnd_q};
    assign div_acc_n  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_work_n = {work_q[WIDTH-2:0], div_ge};

    assign acc_n  = is_div_q ? div_acc_n  : mul_acc_n;
    assign work_n = is_div_q ? div_work_n : mul_work_n;

    assign prod     = {acc_n, work_n};
    assign prod_fix = neg_q ? (~prod + 1'b1) : prod;
    assign quo_fix  = neg_q ? (~work_n + 1'b1) : work_n;
    assign rem_fix  = rem_neg_q ? (~acc_n + 1'b1) : acc_n;
    assign fix_hi   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign fix_lo   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];

    always_comb begin
        simple_res = {WIDTH{1'b0}};
        case (operation)
            OP_AND:  simple_res = data1 & data2;
            OP_OR:   simple_res = data1 | data2;
            OP_ADD:  simple_res = data1 + data2;
            OP_SUB:  simple_res = data1 - data2;
            OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
            OP_NOR:  simple_res = ~(data1 | data2);
            default: simple_res = {WIDTH{1'b0}};
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        work_d       = work_q;
        opnd_d       = opnd_q;
        is_div_d     = is_div_q;
        neg_d        = neg_q;
        rem_neg_d    = rem_neg_q;
        done_d       = 1'b0;
        alu_result_d = alu_result_q;
        zero_d       = zero_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        dbz_d        = dbz_q;
        case (state_q)
            CALC: begin
                cnt_d  = cnt_q + 1'b1;
                acc_d  = acc_n;
                work_d = work_n;
                // The last iteration's result is sign-fixed on the way into FIX.
                if (cnt_q == LAST_ITER) begin
                    state_d      = FIX;
                    done_d       = 1'b1;
                    hi_d         = fix_hi;
                    lo_d         = fix_lo;
                    alu_result_d = fix_lo;
                    zero_d       = (fix_lo == {WIDTH{1'b0}});
                end
            end
            default: begin
                state_d = IDLE;
                if (start) begin
                    dbz_d = 1'b0;
                    case (operation)
                        OP_MULT, OP_MULTU: begin
                            state_d   = CALC;
                            cnt_d     = '0;
                            acc_d     = '0;
                            opnd_d    = a_abs;
                            work_d    = b_abs;
                            is_div_d  = 1'b0;
                            neg_d     = a_neg ^ b_neg;
                            rem_neg_d = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (data2 == {WIDTH{1'b0}}) begin
                                done_d       = 1'b1;
                                hi_d         = data1;
                                lo_d         = {WIDTH{1'b1}};
                                alu_result_d = {WIDTH{1'b1}};
                                zero_d       = 1'b0;
                                dbz_d        = 1'b1;
                            end else begin
                                state_d   = CALC;
                                cnt_d     = '0;
                                acc_d     = '0;
                                opnd_d    = b_abs;
                                work_d    = a_abs;
                                is_div_d  = 1'b1;
                                neg_d     = a_neg ^ b_neg;
                                rem_neg_d = a_neg;
                            end
                        end
                        default: begin
                            done_d       = 1'b1;
                            alu_result_d = simple_res;
                            zero_d       = (simple_res == {WIDTH{1'b0}});
                        end
                    endcase
                end
            end
        endcase
        busy_d = (state_d == CALC);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            work_q       <= '0;
            opnd_q       <= '0;
            is_div_q     <= 1'b0;
            neg_q        <= 1'b0;
            rem_neg_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            alu_result_q <= '0;
            zero_q       <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            dbz_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            work_q       <= work_d;
            opnd_q       <= opnd_d;
            is_div_q     <= is_div_d;
            neg_q        <= neg_d;
            rem_neg_q    <= rem_neg_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            alu_result_q <= alu_result_d;
            zero_q       <= zero_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            dbz_q        <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign alu_result  = alu_result_q;
    assign zero        = zero_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;
endmodule
